pic_8259a_ctrl: RTL and testbench
=================================

Name: pic_8259a_ctrl

Overview:
- Clocked, synthesisable 8259A-style programmable interrupt controller for an 8086-style host bus.
- Accepts the ICW1/ICW2/(ICW3)/(ICW4) initialisation sequence and OCW1–OCW3, and prioritises 8 interrupt requests.
- Raises `int`, and returns an 8-bit vector on the second INTA pulse.
- Single (non-cascaded) operation only; sits between the CPU bus and peripheral IRQ lines.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `ir`, `wr_n`, `rd_n`, `inta_n`.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n  in  1  chip select, active-low.
- wr_n  in  1  write strobe, active-low.
- rd_n  in  1  read strobe, active-low.
- a0  in  1  register address line.
- d  inout  8  bidirectional data bus; high-Z unless driving.
- cas  inout  4  cascade lines; always high-Z (single mode only).
- sp_en_n  in  1  slave program/enable; ignored.
- int  out  1  interrupt request to CPU, active-high.
- ir  in  8  interrupt requests; IR0 has the highest fixed priority.
- inta_n  in  1  interrupt acknowledge, active-low.

Behaviour:
- Reset values:
  - `int` = 0, `d` = Z, `cas` = Z.
  - IRR = ISR = IMR = 0.
  - Init state IDLE (uninitialised), vector base 0, LTIM = 0, AEOI = 0.
  - OCW3 read-select = IRR.
- Write handling:
  - While `cs_n` = 0 and `wr_n` = 0 (synchronised), capture `d` and `a0` every clock.
  - Commit on the synchronised rising edge of `wr_n`, one clock after it is seen.
- Init FSM states: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
  - ICW1 (`a0`=0, d[4]=1) from any state:
    - Store IC4 = d[0], SNGL = d[1], LTIM = d[3].
    - Clear IMR, ISR, IRR, AEOI and the read-select.
    - Go to WAIT_ICW2.
  - ICW2 (`a0`=1): store base = d[7:3]. Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - ICW3 (`a0`=1): stored and ignored. Next state is WAIT_ICW4 if IC4=1, else READY.
  - ICW4 (`a0`=1): AEOI = d[1]; d[0] (uPM) is ignored, 8086 mode is always used. Go to READY.
- Operation commands (READY only):
  - OCW1 (`a0`=1): IMR = d.
  - OCW2 (`a0`=0, d[4:3]=00):
    - d[7:5]=001: non-specific EOI, clears the highest-priority ISR bit.
    - d[7:5]=011: specific EOI, clears ISR[d[2:0]].
    - Other codes are ignored unless PIC8259_ROTATE_EN is defined.
  - OCW3 (`a0`=0, d[4:3]=01): if d[1]=1, read-select = d[0] (0 = IRR, 1 = ISR).
- Reads (`cs_n`=0, `rd_n`=0, `inta_n`=1): `d` is driven combinationally.
  - `a0`=0 gives IRR or ISR, per read-select.
  - `a0`=1 gives IMR.
- IRR capture (after synchronisation):
  - Edge mode (LTIM=0): a rising edge on ir[i] sets IRR[i]; ir[i] low clears IRR[i] before acknowledge.
  - Level mode (LTIM=1): IRR[i] follows ir[i].
  - Nothing is captured while not READY.
- Resolver:
  - `int` = 1 (registered) when READY and the highest-priority bit of (IRR & ~IMR) has higher priority than the highest ISR bit.
  - Masked IRR bits stay latched.
- INTA sequence (synchronised falling edges of `inta_n`; a constant-low `inta_n` is not a pulse):
  - First pulse:
    - Set ISR[n] for the winning level n and clear IRR[n].
    - Drop `int`.
    - If there is no pending request, latch n = 7 (spurious).
  - Second pulse: drive `d` = {base, n} while `inta_n` = 0.
    - If AEOI = 1, clear ISR[n] on the rising edge of `inta_n`.
  - Pulses when not READY are ignored.
- Simultaneous events: an ICW1 write has precedence over an INTA edge in the same clock. Reads and INTA vector driving are mutually exclusive; INTA wins.
- Reset mid-sequence returns to IDLE immediately.

Optional Feature:
- Macro PIC8259_ROTATE_EN.
- When defined:
  - OCW2 101 = rotate on non-specific EOI: clear the highest ISR bit and make that level lowest priority.
  - OCW2 111 = rotate on specific EOI: clear ISR[d[2:0]] and make that level lowest.
  - OCW2 110 = set priority: d[2:0] becomes the lowest priority.
  - A 3-bit lowest-priority pointer (reset 7) rotates the resolver.
- When undefined: fixed priority, IR0 highest; those OCW2 codes are ignored.

Decomposition:
- Package pic8259_pkg holds:
  - Init FSM state enum.
  - OCW2 command-code constants.
  - ICW1/OCW3 discriminator bit positions.
- One sub-module, pic8259_prio_resolver: combinational, takes request vector, ISR, and lowest-priority pointer; outputs valid flag and 3-bit level.

Test Plan:
- Init and single interrupt:
  - Stimulus: ICW1=0x13, ICW2=0xA8, ICW4=0x01, OCW1=0x00, then ir=0x01.
  - Response: `int`=1 within SYNC_STAGES+2 clocks; two INTA pulses; on the second, `d`=0xA8 and ISR=0x01.
- Masking:
  - Stimulus: OCW1=0x01, raise ir[0].
  - Response: `int` stays 0; IRR read (`a0`=0) returns 0x01; OCW1=0x00 makes `int`=1.
- Priority and EOI:
  - Stimulus: ir=0x0A, then INTA pair.
  - Response: vector 0xA9; `int` re-asserts only after OCW2=0x20; the next vector is 0xAB.
- AEOI:
  - Stimulus: ICW4=0x03, raise ir[5], INTA pair.
  - Response: vector 0xAD; ISR=0x00 after the second INTA.
- Readback and reset:
  - Stimulus: OCW3=0x0B.
  - Response: `a0`=0 reads ISR; IMR reads back via `a0`=1; asserting `rst_n`=0 mid-INTA gives `int`=0, `d`=Z, and the FSM returns to IDLE.
- Spurious: INTA pair with no request → vector 0xAF.

Source files
------------

// File: rtl/pic8259_pkg.sv
// Shared types and constants for the 8259A-style interrupt controller.
package pic8259_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ICW2,
    ST_WAIT_ICW3,
    ST_WAIT_ICW4,
    ST_READY
  } init_state_e;

  // OCW2 d[7:5] command codes
  localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI   = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP   = 3'b111;
  localparam logic [2:0] OCW2_SET_PRIO = 3'b110;

  // Bit positions that tell ICW1 / OCW2 / OCW3 apart on an a0=0 write
  localparam int unsigned ICW1_BIT = 4;
  localparam int unsigned OCW3_BIT = 3;

endpackage

// File: rtl/pic8259_prio_resolver.sv
// Combinational priority resolver: scans from the level after i_lowest and
// reports the first request that outranks every in-service level.
module pic8259_prio_resolver (
  input  logic [7:0] i_req,
  input  logic [7:0] i_isr,
  input  logic [2:0] i_lowest,
  output logic       o_valid,
  output logic [2:0] o_level
);

  always_comb begin
    logic       blocked;
    logic [2:0] idx;
    o_valid = 1'b0;
    o_level = 3'd0;
    blocked = 1'b0;
    idx     = 3'd0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = i_lowest + 3'(k) + 3'd1;
      // an in-service level blocks itself and everything below it
      if (i_isr[idx]) blocked = 1'b1;
      if (!blocked && !o_valid && i_req[idx]) begin
        o_valid = 1'b1;
        o_level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_8259a_ctrl.sv
// 8259A-style PIC, single mode, 8086 vectors. Define PIC8259_ROTATE_EN to
// enable the rotating-priority OCW2 commands.
module pic_8259a_ctrl
  import pic8259_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs_n,
  input  logic       i_wr_n,
  input  logic       i_rd_n,
  input  logic       i_a0,
  inout  logic [7:0] io_d,
  inout  logic [3:0] io_cas,
  input  logic       i_sp_en_n,
  output logic       o_int,
  input  logic [7:0] i_ir,
  input  logic       i_inta_n
);

  logic [SYNC_STAGES-1:0]      r_wr_sync, r_rd_sync, r_inta_sync;
  logic [SYNC_STAGES-1:0][7:0] r_ir_sync;
  logic       w_wr_s, w_rd_s, w_inta_s;
  logic [7:0] w_ir_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_sync   <= '1;
      r_rd_sync   <= '1;
      r_inta_sync <= '1;
      r_ir_sync   <= '0;
    end else begin
      r_wr_sync[0]   <= i_wr_n;
      r_rd_sync[0]   <= i_rd_n;
      r_inta_sync[0] <= i_inta_n;
      r_ir_sync[0]   <= i_ir;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_wr_sync[k]   <= r_wr_sync[k-1];
        r_rd_sync[k]   <= r_rd_sync[k-1];
        r_inta_sync[k] <= r_inta_sync[k-1];
        r_ir_sync[k]   <= r_ir_sync[k-1];
      end
    end
  end

  assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
  assign w_inta_s = r_inta_sync[SYNC_STAGES-1];
  assign w_ir_s   = r_ir_sync[SYNC_STAGES-1];

  init_state_e r_state;
  logic       r_wr_prev, r_wr_pend, r_wa0, r_inta_prev;
  logic [7:0] r_wd, r_ir_prev, r_irr, r_isr, r_imr, r_icw3;
  logic [7:0] w_irr_nxt, w_isr_nxt, w_req;
  logic [4:0] r_base;
  logic       r_ic4, r_sngl, r_ltim, r_aeoi, r_rsel, r_int;
  logic       r_inta_cnt, r_ack2, r_vec_spur;
  logic [2:0] r_vec_lvl, w_lowest, w_req_lvl, w_isr_lvl;
  logic       w_req_valid, w_isr_valid, w_ready;
  logic       w_wr_commit, w_icw1, w_cmd_ok, w_ocw, w_ocw2, w_ocw3;
  logic       w_inta_fall, w_inta_rise, w_ack1, w_ack2, w_ack_end;
  logic       w_vec_oe, w_rd_oe, w_d_oe;
  logic [7:0] w_d_out;
  logic       w_unused_ok;

  // Bus data is sampled every clock of a strobe; commit waits for its end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd      <= '0;
      r_wa0     <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wr_prev <= 1'b1;
    end else begin
      r_wr_prev <= w_wr_s;
      if (!i_cs_n && !w_wr_s) begin
        r_wd      <= io_d;
        r_wa0     <= i_a0;
        r_wr_pend <= 1'b1;
      end else if (w_wr_commit) begin
        r_wr_pend <= 1'b0;
      end
    end
  end

  assign w_wr_commit = w_wr_s & ~r_wr_prev & r_wr_pend;
  assign w_ready     = (r_state == ST_READY);
  assign w_icw1      = w_wr_commit & ~r_wa0 & r_wd[ICW1_BIT];
  assign w_cmd_ok    = w_wr_commit & ~w_icw1;
  assign w_ocw       = w_cmd_ok & w_ready & ~r_wa0;
  assign w_ocw2      = w_ocw & ~r_wd[ICW1_BIT] & ~r_wd[OCW3_BIT];
  assign w_ocw3      = w_ocw & ~r_wd[ICW1_BIT] &  r_wd[OCW3_BIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ic4   <= 1'b0;
      r_sngl  <= 1'b0;
      r_ltim  <= 1'b0;
      r_aeoi  <= 1'b0;
      r_rsel  <= 1'b0;
      r_base  <= '0;
      r_icw3  <= '0;
      r_imr   <= '0;
    end else if (w_icw1) begin
      r_ic4   <= r_wd[0];
      r_sngl  <= r_wd[1];
      r_ltim  <= r_wd[3];
      r_aeoi  <= 1'b0;
      r_rsel  <= 1'b0;
      r_imr   <= '0;
      r_state <= ST_WAIT_ICW2;
    end else if (w_cmd_ok && r_wa0) begin
      case (r_state)
        ST_WAIT_ICW2: begin
          r_base  <= r_wd[7:3];
          r_state <= !r_sngl ? ST_WAIT_ICW3 : (r_ic4 ? ST_WAIT_ICW4 : ST_READY);
        end
        ST_WAIT_ICW3: begin
          r_icw3  <= r_wd;
          r_state <= r_ic4 ? ST_WAIT_ICW4 : ST_READY;
        end
        ST_WAIT_ICW4: begin
          r_aeoi  <= r_wd[1];
          r_state <= ST_READY;
        end
        ST_READY: r_imr <= r_wd;
        default: ;
      endcase
    end else if (w_ocw3 && r_wd[1]) begin
      r_rsel <= r_wd[0];
    end
  end

`ifdef PIC8259_ROTATE_EN
  logic [2:0] r_lowest;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lowest <= 3'd7;
    end else if (w_icw1) begin
      r_lowest <= 3'd7;
    end else if (w_ocw2) begin
      case (r_wd[7:5])
        OCW2_ROT_NS:                if (w_isr_valid) r_lowest <= w_isr_lvl;
        OCW2_ROT_SP, OCW2_SET_PRIO: r_lowest <= r_wd[2:0];
        default: ;
      endcase
    end
  end
  assign w_lowest = r_lowest;
`else
  assign w_lowest = 3'd7;
`endif

  assign w_req = r_irr & ~r_imr;

  pic8259_prio_resolver u_req_res (
    .i_req    (w_req),
    .i_isr    (r_isr),
    .i_lowest (w_lowest),
    .o_valid  (w_req_valid),
    .o_level  (w_req_lvl)
  );

  pic8259_prio_resolver u_isr_res (
    .i_req    (r_isr),
    .i_isr    ('0),
    .i_lowest (w_lowest),
    .o_valid  (w_isr_valid),
    .o_level  (w_isr_lvl)
  );

  assign w_inta_fall = ~w_inta_s &  r_inta_prev;
  assign w_inta_rise =  w_inta_s & ~r_inta_prev;
  assign w_ack1      = w_inta_fall & w_ready & ~r_inta_cnt & ~w_icw1;
  assign w_ack2      = w_inta_fall & w_ready &  r_inta_cnt & ~w_icw1;
  assign w_ack_end   = w_inta_rise & r_ack2 & ~w_icw1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inta_prev <= 1'b1;
      r_inta_cnt  <= 1'b0;
      r_ack2      <= 1'b0;
      r_vec_lvl   <= '0;
      r_vec_spur  <= 1'b0;
    end else begin
      r_inta_prev <= w_inta_s;
      if (w_icw1) begin
        r_inta_cnt <= 1'b0;
        r_ack2     <= 1'b0;
      end else begin
        if (w_ack1) begin
          r_inta_cnt <= 1'b1;
          r_vec_lvl  <= w_req_valid ? w_req_lvl : 3'd7;
          r_vec_spur <= ~w_req_valid;
        end
        if (w_ack2) begin
          r_inta_cnt <= 1'b0;
          r_ack2     <= 1'b1;
        end
        if (w_ack_end) r_ack2 <= 1'b0;
      end
    end
  end

  always_comb begin
    w_irr_nxt = r_irr;
    w_isr_nxt = r_isr;
    if (w_icw1) begin
      w_irr_nxt = '0;
      w_isr_nxt = '0;
    end else begin
      if (w_ready) begin
        if (r_ltim) w_irr_nxt = w_ir_s;
        else        w_irr_nxt = (r_irr | (w_ir_s & ~r_ir_prev)) & w_ir_s;
      end
      if (w_ack1 && w_req_valid) begin
        w_irr_nxt[w_req_lvl] = 1'b0;
        w_isr_nxt[w_req_lvl] = 1'b1;
      end
      if (w_ack_end && r_aeoi && !r_vec_spur) w_isr_nxt[r_vec_lvl] = 1'b0;
      if (w_ocw2) begin
        case (r_wd[7:5])
          OCW2_NS_EOI: if (w_isr_valid) w_isr_nxt[w_isr_lvl] = 1'b0;
          OCW2_SP_EOI: w_isr_nxt[r_wd[2:0]] = 1'b0;
`ifdef PIC8259_ROTATE_EN
          OCW2_ROT_NS: if (w_isr_valid) w_isr_nxt[w_isr_lvl] = 1'b0;
          OCW2_ROT_SP: w_isr_nxt[r_wd[2:0]] = 1'b0;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irr     <= '0;
      r_isr     <= '0;
      r_ir_prev <= '0;
      r_int     <= 1'b0;
    end else begin
      r_irr     <= w_irr_nxt;
      r_isr     <= w_isr_nxt;
      r_ir_prev <= w_ir_s;
      r_int     <= w_ready & w_req_valid & ~w_ack1 & ~w_icw1;
    end
  end

  assign o_int = r_int;

  // The INTA vector takes the bus over any concurrent register read.
  assign w_vec_oe = r_ack2 & ~w_inta_s;
  assign w_rd_oe  = ~i_cs_n & ~w_rd_s & w_inta_s;
  assign w_d_oe   = w_vec_oe | w_rd_oe;

  always_comb begin
    w_d_out = i_a0 ? r_imr : (r_rsel ? r_isr : r_irr);
    if (w_vec_oe) w_d_out = {r_base, r_vec_lvl};
  end

  assign io_d   = w_d_oe ? w_d_out : 'z;
  assign io_cas = 'z;

  assign w_unused_ok = ^{i_sp_en_n, r_icw3};

endmodule

// File: tb/tb_pic_8259a_ctrl.sv
// Directed self-checking bench for pic_8259a_ctrl using an expected-value queue.
module tb_pic_8259a_ctrl;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, wr_n, rd_n, a0, sp_en_n, inta_n;
  logic [7:0] ir;
  logic       tb_oe;
  logic [7:0] tb_d;
  wire  [7:0] d_bus;
  wire  [3:0] cas;
  logic       irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       q_tag[$];
  logic [7:0]  q_val[$];
  logic [7:0]  rv;

  assign d_bus = tb_oe ? tb_d : 8'hzz;

  always #5 clk = ~clk;

  pic_8259a_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cs_n    (cs_n),
    .i_wr_n    (wr_n),
    .i_rd_n    (rd_n),
    .i_a0      (a0),
    .io_d      (d_bus),
    .io_cas    (cas),
    .i_sp_en_n (sp_en_n),
    .o_int     (irq),
    .i_ir      (ir),
    .i_inta_n  (inta_n)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    q_tag.push_back(tag);
    q_val.push_back(v);
  endtask

  task automatic check(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    n_cmp++;
    if (q_val.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: observed %h, expected a queued value", obs);
      return;
    end
    t = q_tag.pop_front();
    e = q_val.pop_front();
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic bus_write(input logic a, input logic [7:0] v);
    cs_n = 1'b0; a0 = a; tb_d = v; tb_oe = 1'b1; wr_n = 1'b0;
    tick(SYNC + 2);
    wr_n = 1'b1;
    tick(SYNC + 2);
    cs_n = 1'b1; tb_oe = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] v);
    cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    tick(SYNC + 2);
    v = d_bus;
    rd_n = 1'b1; cs_n = 1'b1;
    tick(SYNC + 1);
  endtask

  task automatic wait_int(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      tick(1);
      if (irq) break;
    end
    push(tag, 8'h01);
    check({7'd0, irq});
  endtask

  task automatic inta_pair(input string tag, input logic [7:0] vec);
    inta_n = 1'b0; tick(SYNC + 2);
    inta_n = 1'b1; tick(SYNC + 2);
    push({tag, "_int_drop"}, 8'h00);
    check({7'd0, irq});
    push({tag, "_vector"}, vec);
    inta_n = 1'b0; tick(SYNC + 2);
    check(d_bus);
    inta_n = 1'b1; tick(SYNC + 2);
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0;
    sp_en_n = 1'b1; inta_n = 1'b1; ir = 8'h00; tb_oe = 1'b0; tb_d = 8'h00;
    tick(3);
    push("reset_int", 8'h00);  check({7'd0, irq});
    push("reset_d_hiz", 8'h00); check({7'd0, dut.w_d_oe});
    rst_n = 1'b1;
    tick(2);

    // init: edge mode, single, IC4; base 0xA8; normal EOI; nothing masked
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'hA8);
    bus_write(1'b1, 8'h01);
    bus_write(1'b1, 8'h00);
    push("reset_irr", 8'h00); bus_read(1'b0, rv); check(rv);

    ir = 8'h01;
    wait_int("single_int", SYNC + 2);
    inta_pair("single", 8'hA8);
    bus_write(1'b0, 8'h0B);
    push("single_isr", 8'h01); bus_read(1'b0, rv); check(rv);
    bus_write(1'b0, 8'h0A);
    ir = 8'h00;
    bus_write(1'b0, 8'h20);
    tick(4);

    // masking
    bus_write(1'b1, 8'h01);
    ir = 8'h01;
    tick(8);
    push("masked_int", 8'h00); check({7'd0, irq});
    push("masked_irr", 8'h01); bus_read(1'b0, rv); check(rv);
    bus_write(1'b1, 8'h00);
    wait_int("unmask_int", 8);
    inta_pair("unmask", 8'hA8);
    ir = 8'h00;
    bus_write(1'b0, 8'h20);
    tick(4);

    // priority and non-specific EOI
    ir = 8'h0A;
    wait_int("prio_int", SYNC + 2);
    inta_pair("prio_ir1", 8'hA9);
    tick(6);
    push("prio_blocked", 8'h00); check({7'd0, irq});
    bus_write(1'b0, 8'h20);
    wait_int("prio_after_eoi", 8);
    inta_pair("prio_ir3", 8'hAB);
    ir = 8'h00;
    bus_write(1'b0, 8'h20);
    tick(4);

    // automatic EOI
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'hA8);
    bus_write(1'b1, 8'h03);
    bus_write(1'b1, 8'h00);
    ir = 8'h20;
    wait_int("aeoi_int", SYNC + 2);
    inta_pair("aeoi", 8'hAD);
    ir = 8'h00;
    bus_write(1'b0, 8'h0B);
    push("aeoi_isr", 8'h00); bus_read(1'b0, rv); check(rv);

    // readback
    bus_write(1'b1, 8'h5A);
    push("imr_read", 8'h5A); bus_read(1'b1, rv); check(rv);
    bus_write(1'b1, 8'h00);

    // spurious
    tick(4);
    inta_pair("spurious", 8'hAF);

    // reset in the middle of an acknowledge
    ir = 8'h04;
    wait_int("midreset_int", SYNC + 2);
    inta_n = 1'b0; tick(SYNC + 2);
    inta_n = 1'b1; tick(SYNC + 2);
    inta_n = 1'b0; tick(SYNC + 2);
    push("midreset_vec", 8'hAA); check(d_bus);
    rst_n = 1'b0;
    tick(1);
    push("midreset_int_low", 8'h00); check({7'd0, irq});
    push("midreset_d_hiz", 8'h00);   check({7'd0, dut.w_d_oe});
    inta_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    ir = 8'h00; tick(4);
    ir = 8'h04; tick(10);
    push("idle_no_int", 8'h00); check({7'd0, irq});
    bus_write(1'b1, 8'hFF);
    push("idle_imr", 8'h00); bus_read(1'b1, rv); check(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
